// File: rtl/priority_decoder_4_bit_pkg.sv
// Shared definitions for the 4-bit priority decoder: encoded/decoded widths,
// buffer occupancy states and the {A,V} -> one-hot line decode function.
package priority_decoder_4_bit_pkg;

    localparam int ENC_W  = 2;
    localparam int LINE_N = 4;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } occ_t;

    // Index A selects the active line; V=0 means no line is active.
    function automatic logic [LINE_N-1:0] decode_line(input logic [ENC_W-1:0] a,
                                                      input logic             v);
        decode_line = v ? (LINE_N'(1) << a) : '0;
    endfunction

endpackage

// File: rtl/priority_decoder_4_bit_skid_buf.sv
// decoder_skid_buf: 2-entry ready/valid FIFO with strict arrival order.
// Ready is decoded from the occupancy flop, so no input reaches an output combinationally.
module decoder_skid_buf
    import priority_decoder_4_bit_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_t         state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push, pop;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = in_data;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    state_d = TWO;
                    tail_d  = in_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: state uses <= so all flops update together from pre-edge values.
    // NOTE: the two data entries are reset too, so the head shows zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/priority_decoder_4_bit.sv
// Priority decoder: {A,V} stream -> registered one-hot Y stream through a 2-entry buffer.
// Optional per-line saturating hit counters enabled by PRIORITY_DECODER_HIT_COUNT_EN.
module priority_decoder_4_bit
    import priority_decoder_4_bit_pkg::*;
#(
    parameter int HIT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ENC_W-1:0]        A,
    input  logic                    V,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LINE_N-1:0]       Y,
    output logic                    V_out,
    input  logic                    hit_clr,
    output logic [LINE_N*HIT_W-1:0] hit_cnt
);

    localparam int WORD_W = LINE_N + 1;

    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] out_word;

    // Decode on the way in so the buffer holds ready-to-drive {Y,V_out} words.
    assign in_word = {decode_line(A, V), V};

    decoder_skid_buf #(
        .W(WORD_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_word),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_word)
    );

    assign Y     = out_word[WORD_W-1:1];
    assign V_out = out_word[0];

`ifdef PRIORITY_DECODER_HIT_COUNT_EN
    localparam logic [HIT_W-1:0] CNT_MAX = '1;

    logic [LINE_N-1:0][HIT_W-1:0] cnt_q;

    // Clear takes precedence over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || hit_clr) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready && V_out) begin
            for (int i = 0; i < LINE_N; i++) begin
                if (Y[i] && cnt_q[i] != CNT_MAX) begin
                    cnt_q[i] <= cnt_q[i] + HIT_W'(1);
                end
            end
        end
    end

    assign hit_cnt = cnt_q;
`else
    logic unused_hit_clr;

    assign unused_hit_clr = hit_clr;
    assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_priority_decoder_4_bit.sv
// Bench for priority_decoder_4_bit: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the decoded stream.
module tb_priority_decoder_4_bit;

    localparam int HW = 2;
    localparam int CMAX = (1 << HW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    A;
    logic          V;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    Y;
    logic          V_out;
    logic          hit_clr;
    logic [4*HW-1:0] hit_cnt;

    typedef struct {
        logic [1:0] a;
        logic       v;
    } word_t;

    word_t q[$];
    int    cnt[4];
    int    checks = 0;
    int    errors = 0;
    bit    after_reset;

    always #5 clk = ~clk;

    priority_decoder_4_bit #(
        .HIT_W(HW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .V        (V),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Y        (Y),
        .V_out    (V_out),
        .hit_clr  (hit_clr),
        .hit_cnt  (hit_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the transfers it predicts, compare.
    task automatic step(input bit iv, input logic [1:0] a, input logic v,
                        input bit ordy, input bit clr, input bit r);
        bit     in_fire, out_fire;
        word_t  w, h;
        logic [4*HW-1:0] exp_cnt;
        logic [3:0] exp_y;

        rst       = r;
        in_valid  = iv;
        A         = iv ? a : 2'bxx;
        V         = iv ? v : 1'bx;
        out_ready = ordy;
        hit_clr   = clr;

        in_fire  = !r && iv && (q.size() < 2);
        out_fire = !r && ordy && (q.size() > 0);
        w.a = a;
        w.v = v;

        @(posedge clk);
        #1;

        if (r) begin
            q.delete();
            foreach (cnt[i]) cnt[i] = 0;
            after_reset = 1'b1;
        end else begin
            if (out_fire) begin
                h = q.pop_front();
`ifdef PRIORITY_DECODER_HIT_COUNT_EN
                if (h.v && cnt[h.a] < CMAX) cnt[h.a]++;
`endif
            end
            if (clr) foreach (cnt[i]) cnt[i] = 0;
            if (in_fire) q.push_back(w);
            if (in_fire || out_fire) after_reset = 1'b0;
        end

        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            exp_y = q[0].v ? 4'(1 << q[0].a) : 4'd0;
            check("Y", 32'(Y), 32'(exp_y));
            check("V_out", 32'(V_out), 32'(q[0].v));
        end else if (after_reset) begin
            check("Y_reset", 32'(Y), 32'd0);
            check("V_out_reset", 32'(V_out), 32'd0);
        end
        for (int i = 0; i < 4; i++) exp_cnt[i*HW +: HW] = HW'(cnt[i]);
        check("hit_cnt", 32'(hit_cnt), 32'(exp_cnt));
    endtask

    initial begin
        after_reset = 1'b0;

        // Reset state
        step(0, 2'd0, 1'b0, 1, 0, 1);
        step(0, 2'd0, 1'b0, 1, 0, 0);

        // Single word A=2, then its pop
        step(1, 2'd2, 1'b1, 1, 0, 0);
        step(0, 2'd0, 1'b0, 1, 0, 0);

        // V=0 word passes through without counting
        step(1, 2'd3, 1'b0, 1, 0, 0);
        step(0, 2'd0, 1'b0, 1, 0, 0);

        // Stall: fill to TWO, third offer refused, then drain
        step(1, 2'd0, 1'b1, 0, 0, 0);
        step(1, 2'd1, 1'b1, 0, 0, 0);
        step(1, 2'd2, 1'b1, 0, 0, 0);
        step(1, 2'd2, 1'b1, 1, 0, 0);
        step(1, 2'd2, 1'b1, 1, 0, 0);
        step(0, 2'd0, 1'b0, 1, 0, 0);
        step(0, 2'd0, 1'b0, 1, 0, 0);

        // Streaming 3,3,1,0 after a counter clear
        step(0, 2'd0, 1'b0, 1, 1, 0);
        step(1, 2'd3, 1'b1, 1, 0, 0);
        step(1, 2'd3, 1'b1, 1, 0, 0);
        step(1, 2'd1, 1'b1, 1, 0, 0);
        step(1, 2'd0, 1'b1, 1, 0, 0);
        step(0, 2'd0, 1'b0, 1, 0, 0);
        step(0, 2'd0, 1'b0, 1, 0, 0);

        // Saturation: five hits on line 1, then clear during a sixth transfer
        step(0, 2'd0, 1'b0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 2'd1, 1'b1, 1, 0, 0);
        step(0, 2'd0, 1'b0, 1, 0, 0);
        step(1, 2'd1, 1'b1, 1, 0, 0);
        step(0, 2'd0, 1'b0, 1, 1, 0);
        step(0, 2'd0, 1'b0, 1, 0, 0);

        // Reset with the buffer full: old words must never appear
        step(1, 2'd3, 1'b1, 0, 0, 0);
        step(1, 2'd2, 1'b1, 0, 0, 0);
        step(0, 2'd0, 1'b0, 0, 0, 1);
        step(0, 2'd0, 1'b0, 1, 0, 0);
        step(1, 2'd1, 1'b1, 1, 0, 0);
        step(0, 2'd0, 1'b0, 1, 0, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 4) != 0),
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 79) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_decoder_4_bit.md
# priority_decoder_4_bit

Receiving-side counterpart of the 4-bit priority encoder. Accepts encoded words (2-bit index `A` plus valid flag `V`) on a ready/valid stream and regenerates the one-hot 4-bit line vector `Y` on a registered output stream. A 2-entry buffer absorbs downstream stalls without dropping words. Optional per-line saturating hit counters provide observability. Sits directly after the encoder, or after any link carrying its `{A,V}` output.

## Interface

Parameters:
- `HIT_W`, default 8: width of each per-line hit counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  block can accept a word this cycle.
- `A`  in  2  encoded index of highest active line.
- `V`  in  1  encoder valid flag; 0 means no line active.
- `out_valid`  out  1  decoded word present.
- `out_ready`  in  1  downstream accepts the word this cycle.
- `Y`  out  4  one-hot decoded lines.
- `V_out`  out  1  copy of `V` for the word on `Y`.
- `hit_clr`  in  1  clears all hit counters.
- `hit_cnt`  out  4*HIT_W  packed counters; line i at `[i*HIT_W +: HIT_W]`.

## Operation

- Decode rule:
  - `Y = V ? (4'b0001 << A) : 4'b0000`.
  - `V_out = V`.
  - `Y` is always one-hot or zero.
- Transfer rules:
  - Input transfer when `in_valid & in_ready`.
  - Output transfer when `out_valid & out_ready`.
- Buffer: 2-entry FIFO of decoded `{Y,V_out}` words, strict arrival order. Occupancy states:
  - EMPTY -> ONE on push.
  - ONE -> TWO on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE -> ONE on push and pop together.
  - TWO -> ONE on pop; no push is possible while in TWO.
- Handshake signals:
  - `in_ready = (state != TWO)`, registered.
  - `out_valid = (state != EMPTY)`.
  - `Y`/`V_out` always show the head entry, and hold stable while `out_valid & ~out_ready`.
- Words with `V=0` are passed through like any other word; they are not dropped.
- `in_valid` low: `A`/`V` are ignored (don't-care, including x).
- Hit counters:
  - On each output transfer with `V_out=1`, increment the counter for the set line of `Y`.
  - Counters saturate at `2**HIT_W-1`.
  - `hit_clr` zeroes all counters. If `hit_clr` and an increment occur in the same cycle, clear wins.

## Timing

- Reset values:
  - State EMPTY.
  - `in_ready=1` in the first cycle after reset.
  - `out_valid=0`, `Y=4'b0000`, `V_out=0`.
  - All `hit_cnt=0`.
- Latency: a word accepted at edge n appears on `Y` with `out_valid=1` after edge n (one cycle). There is no combinational path from input to output.
- Throughput: one word per cycle when `out_ready` is held high.
- Stall: `in_ready` falls the cycle after the buffer becomes TWO, and rises the cycle after the first pop.
- Reset mid-operation: buffered words are discarded and outputs return to their reset values on the next edge. Upstream must re-offer the word.
- Counter values are visible one cycle after the transfer edge that increments them.

## Configuration

- Macro `PRIORITY_DECODER_HIT_COUNT_EN`:
  - Defined: hit counters implemented as described above.
  - Undefined: no counter flops; `hit_cnt` is tied to 0 and `hit_clr` is ignored. Datapath and handshake behaviour are identical in both builds.

## Structure

- Shared package holds:
  - localparams `ENC_W=2` and `LINE_N=4`.
  - Occupancy enum `{EMPTY, ONE, TWO}`.
  - The decode function mapping `{A,V}` to `Y`, shared with the encoder bench checker.
- One sub-module, `decoder_skid_buf`: the 2-entry ready/valid buffer, parameterised on data width (5 bits here).
- Decode logic and counters live in the top level.

## Test plan

- Reset, then push `A=2'b10, V=1` with `out_ready=1`: next cycle `Y=4'b0100`, `V_out=1`, `out_valid=1`. After the pop, `hit_cnt[2]=1`.
- Push `V=0, A=2'b11`: `Y=4'b0000`, `V_out=0`, word delivered, no counter changes.
- Hold `out_ready=0` and push indices 0, 1, 2 back to back: first two words accepted, `in_ready=0` on the third attempt. Release `out_ready`: `Y` shows `0001` then `0010`, then the third word is accepted.
- Streaming with `out_ready=1`, indices 3,3,1,0: outputs `1000,1000,0010,0001` on consecutive cycles. With the macro defined, `hit_cnt` ends with line3=2, line1=1, line0=1, line2=0.
- `HIT_W=2`, push index 1 five times: counter saturates at 3. Assert `hit_clr` during a sixth transfer: counter reads 0.
- Fill the buffer to TWO, assert `rst` for one cycle: `out_valid=0`, `Y=0000`, `in_ready=1`; old words are never emitted.
